// File: rtl/mips_cache_mem_bridge.sv
// mips_cache_mem_bridge: refill engine between mips_cache_data and an
// Avalon-MM pipelined read port. One outstanding read at a time; the
// fetched word is returned to the cache as a one-cycle data_valid pulse.
// Optional build macro: MIPS_CACHE_BRIDGE_TIMEOUT_EN enables a bus timeout
// that returns 32'hDEADBEEF and raises a sticky err flag.
module mips_cache_mem_bridge #(
  parameter logic [31:0] ADDR_OFFSET    = 32'h00000000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req_addr,
  input  logic        req_en,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        busy,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] avm_address_q, avm_address_d;
  logic        drop_q, drop_d;
  logic [31:0] data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        busy_q, busy_d;
  logic        avm_read_q, avm_read_d;

`ifdef MIPS_CACHE_BRIDGE_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  // State register plus registered outputs; rst is asynchronous active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      addr_q        <= 32'h00000000;
      avm_address_q <= 32'h00000000;
      drop_q        <= 1'b0;
      data_out_q    <= 32'h00000000;
      data_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      avm_read_q    <= 1'b0;
`ifdef MIPS_CACHE_BRIDGE_TIMEOUT_EN
      cnt_q         <= 32'd0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      avm_address_q <= avm_address_d;
      drop_q        <= drop_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      busy_q        <= busy_d;
      avm_read_q    <= avm_read_d;
`ifdef MIPS_CACHE_BRIDGE_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  // Next-state logic: request latch, bus handshake, drop tracking, data capture.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    avm_address_d = avm_address_q;
    drop_d        = drop_q;
    data_out_d    = data_out_q;
    case (state_q)
      S_IDLE: begin
        if (req_en) begin
          addr_d        = req_addr;
          // Carry out of the 32-bit add is discarded on purpose (wrap).
          avm_address_d = {req_addr[29:0], 2'b00} + ADDR_OFFSET;
          drop_d        = 1'b0;
          state_d       = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        // The read cannot be aborted; remember that the cache gave up.
        if (!req_en) drop_d = 1'b1;
        else         drop_d = drop_q;
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            data_out_d = avm_readdata;
            state_d    = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (!req_en) drop_d = 1'b1;
        else         drop_d = drop_q;
        if (avm_readdatavalid) begin
          data_out_d = avm_readdata;
          state_d    = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (drop_q) state_d = S_IDLE;
        else        state_d = S_DONE;
      end
      S_DONE: begin
        // Stay here until the cache releases stall or moves to another line,
        // so the same line is not fetched twice.
        if (!req_en || (req_addr != addr_q)) state_d = S_IDLE;
        else                                 state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef MIPS_CACHE_BRIDGE_TIMEOUT_EN
    err_d = err_q;
    if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      cnt_d = cnt_q + 32'd1;
      // A real completion in the same cycle wins over the timeout.
      if ((state_d != S_RESP) && (cnt_q == TIMEOUT_LAST)) begin
        state_d    = S_RESP;
        data_out_d = 32'hDEADBEEF;
        err_d      = 1'b1;
      end else begin
        state_d = state_d;
      end
    end else begin
      cnt_d = 32'd0;
    end
`endif
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    busy_d       = 1'b0;
    avm_read_d   = 1'b0;
    data_valid_d = 1'b0;
    if (state_d != S_IDLE) busy_d = 1'b1;
    else                   busy_d = 1'b0;
    if (state_d == S_REQ) avm_read_d = 1'b1;
    else                  avm_read_d = 1'b0;
    if ((state_d == S_RESP) && !drop_d) data_valid_d = 1'b1;
    else                                data_valid_d = 1'b0;
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign busy        = busy_q;
  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;

`ifdef MIPS_CACHE_BRIDGE_TIMEOUT_EN
  assign err = err_q;
`else
  // No timeout hardware in this build; TIMEOUT_CYCLES only matters with it.
  assign err = (TIMEOUT_CYCLES == 32'd0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_mips_cache_mem_bridge.sv
// Testbench for mips_cache_mem_bridge: table-driven transactions, randomized
// transactions checked against a transaction-level model, and hand-written
// multi-cycle corner cases. Three instances share stimulus and differ only
// in ADDR_OFFSET so address arithmetic and wrap are checked on every read.
module tb_mips_cache_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        req_en = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;

  logic [31:0] data_out, avm_address;
  logic        data_valid, busy, avm_read, err;
  logic [31:0] b_data_out, b_avm_address;
  logic        b_data_valid, b_busy, b_avm_read, b_err;
  logic [31:0] w_data_out, w_avm_address;
  logic        w_data_valid, w_busy, w_avm_read, w_err;

  localparam logic [31:0] OFF_B = 32'hBFC00000;
  localparam logic [31:0] OFF_W = 32'h00000004;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_cache_mem_bridge #(.ADDR_OFFSET(32'h00000000), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_en(req_en),
    .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .err(err));

  mips_cache_mem_bridge #(.ADDR_OFFSET(OFF_B), .TIMEOUT_CYCLES(16)) u_dut_b (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_en(req_en),
    .data_out(b_data_out), .data_valid(b_data_valid), .busy(b_busy),
    .avm_address(b_avm_address), .avm_read(b_avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .err(b_err));

  mips_cache_mem_bridge #(.ADDR_OFFSET(OFF_W), .TIMEOUT_CYCLES(16)) u_dut_w (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_en(req_en),
    .data_out(w_data_out), .data_valid(w_data_valid), .busy(w_busy),
    .avm_address(w_avm_address), .avm_read(w_avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .err(w_err));

  typedef struct {
    logic [31:0] addr;
    int          nwait;   // cycles the slave holds waitrequest
    int          lat;     // cycles from acceptance to readdatavalid
    logic [31:0] word;
    bit          drop;    // cache abandons the request at acceptance
    int          hold;    // cycles req_en stays high after data_valid
    logic [31:0] exp_a0;
    logic [31:0] exp_ab;
    logic [31:0] exp_aw;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the cache and the slave for one transaction, then checks the
  // transaction-level outcome: read cycles, one data_valid unless abandoned,
  // returned word, and an idle bridge at the end.
  task automatic run_txn(input vec_t v, input bit jitter);
    int reads = 0;
    int dvs = 0;
    int cyc = 0;
    int wl;
    int lc = -1;
    int post = 0;
    int first = -1;
    bit acc = 1'b0;
    bit sent = 1'b0;
    bit fin = 1'b0;
    wl = v.nwait;
    req_addr = v.addr;
    req_en = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    while (!fin && cyc < 100) begin
      tick();
      cyc++;
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      if (avm_read) begin
        reads++;
        if (first < 0) first = cyc;
        chk("addr_off0", avm_address, v.exp_a0);
        chk("addr_offB", b_avm_address, v.exp_ab);
        chk("addr_off4", w_avm_address, v.exp_aw);
      end
      if (data_valid) begin
        dvs++;
        chk("dv_data", data_out, v.word);
      end
      if (avm_read && !acc) begin
        if (wl > 0) begin
          avm_waitrequest = 1'b1;
          wl--;
          if (jitter) req_addr = v.addr ^ 32'h00000004;
        end else begin
          avm_waitrequest = 1'b0;
          acc = 1'b1;
          lc = v.lat;
          req_addr = v.addr;
          if (v.drop) req_en = 1'b0;
        end
      end
      if (acc && !sent) begin
        if (lc == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = v.word;
          sent = 1'b1;
        end else begin
          lc--;
        end
      end
      if (dvs > 0) begin
        if (post >= v.hold) req_en = 1'b0;
        post++;
      end
      if (sent && !busy && (v.drop || dvs > 0)) fin = 1'b1;
    end
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    req_en = 1'b0;
    chk("txn_done", 32'(fin), 32'd1);
    chk("read_cycles", 32'(reads), 32'(v.nwait + 1));
    chk("read_latency", 32'(first), 32'd1);
    chk("dv_count", 32'(dvs), v.drop ? 32'd0 : 32'd1);
    chk("data_hold", data_out, v.word);
    chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t rv;
    int hit;

    vecs[0] = '{32'h00000003, 0, 3, 32'h1234ABCD, 1'b0, 1, 32'h0000000C, 32'hBFC0000C, 32'h00000010};
    vecs[1] = '{32'h00000008, 5, 1, 32'hCAFEF00D, 1'b0, 0, 32'h00000020, 32'hBFC00020, 32'h00000024};
    vecs[2] = '{32'h00000001, 2, 0, 32'h0BADC0DE, 1'b0, 4, 32'h00000004, 32'hBFC00004, 32'h00000008};
    vecs[3] = '{32'h00000005, 1, 2, 32'h55AA55AA, 1'b1, 0, 32'h00000014, 32'hBFC00014, 32'h00000018};
    vecs[4] = '{32'h3FFFFFFF, 0, 0, 32'hFFFFFFFF, 1'b0, 2, 32'hFFFFFFFC, 32'hBFBFFFFC, 32'h00000000};
    vecs[5] = '{32'h00000000, 0, 4, 32'h00000001, 1'b1, 0, 32'h00000000, 32'hBFC00000, 32'h00000004};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_addr_offB", b_avm_address, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick();

    // Table-driven transactions
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], 1'b0);
      tick();
    end

    // Randomized transactions against the address/transaction model
    for (int i = 0; i < 20; i++) begin
      rv.addr   = $urandom;
      rv.nwait  = $urandom_range(0, 3);
      rv.lat    = $urandom_range(0, 4);
      rv.word   = $urandom;
      rv.drop   = ($urandom_range(0, 3) == 0);
      rv.hold   = $urandom_range(0, 3);
      rv.exp_a0 = (rv.addr << 2);
      rv.exp_ab = (rv.addr << 2) + OFF_B;
      rv.exp_aw = (rv.addr << 2) + OFF_W;
      run_txn(rv, 1'b1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    // No re-fetch while stall stays high on the same line, then a new line
    req_addr = 32'd5; req_en = 1'b1; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    tick();
    chk("rf_read", 32'(avm_read), 32'd1);
    chk("rf_addr", avm_address, 32'h00000014);
    avm_readdatavalid = 1'b1; avm_readdata = 32'h11112222;
    tick();
    chk("rf_dv", 32'(data_valid), 32'd1);
    chk("rf_data", data_out, 32'h11112222);
    avm_readdatavalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rf_hold_read", 32'(avm_read), 32'd0);
      chk("rf_hold_busy", 32'(busy), 32'd1);
      chk("rf_hold_dv", 32'(data_valid), 32'd0);
    end
    req_addr = 32'd16;
    tick();
    chk("rf_idle_busy", 32'(busy), 32'd0);
    chk("rf_idle_read", 32'(avm_read), 32'd0);
    tick();
    chk("rf_new_read", 32'(avm_read), 32'd1);
    chk("rf_new_addr", avm_address, 32'h00000040);
    avm_readdatavalid = 1'b1; avm_readdata = 32'h33334444;
    tick();
    chk("rf_new_data", data_out, 32'h33334444);
    chk("rf_new_dv", 32'(data_valid), 32'd1);
    avm_readdatavalid = 1'b0; req_en = 1'b0;
    tick();
    tick();
    chk("rf_end_busy", 32'(busy), 32'd0);

    // Cache abandons the request while the bridge is waiting for data
    req_addr = 32'd9; req_en = 1'b1;
    tick();
    chk("ab_read", 32'(avm_read), 32'd1);
    tick();
    chk("ab_wait_read", 32'(avm_read), 32'd0);
    req_en = 1'b0;
    tick();
    avm_readdatavalid = 1'b1; avm_readdata = 32'h77778888;
    tick();
    avm_readdatavalid = 1'b0;
    chk("ab_resp_dv", 32'(data_valid), 32'd0);
    chk("ab_resp_busy", 32'(busy), 32'd1);
    tick();
    chk("ab_idle_busy", 32'(busy), 32'd0);
    chk("ab_idle_dv", 32'(data_valid), 32'd0);
    chk("ab_data", data_out, 32'h77778888);

    // Reset in the middle of a read; the late data must be ignored
    req_addr = 32'd2; req_en = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_read", 32'(avm_read), 32'd0);
    chk("mr_data", data_out, 32'h0);
    chk("mr_addr", avm_address, 32'h0);
    req_en = 1'b0;
    tick();
    rst = 1'b1;
    avm_readdatavalid = 1'b1; avm_readdata = 32'hAAAA5555;
    tick();
    avm_readdatavalid = 1'b0;
    chk("late_data", data_out, 32'h0);
    chk("late_busy", 32'(busy), 32'd0);
    chk("late_dv", 32'(data_valid), 32'd0);

`ifdef MIPS_CACHE_BRIDGE_TIMEOUT_EN
    // Slave accepts but never returns data
    req_addr = 32'd7; req_en = 1'b1; avm_waitrequest = 1'b0;
    hit = -1;
    for (int k = 1; k <= 40 && hit < 0; k++) begin
      tick();
      if (data_valid) hit = k;
    end
    chk("to_cycle", 32'(hit), 32'd17);
    chk("to_data", data_out, 32'hDEADBEEF);
    chk("to_err", 32'(err), 32'd1);
    req_en = 1'b0;
    repeat (3) tick();
    chk("to_err_sticky", 32'(err), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("to_err_clear", 32'(err), 32'd0);
    tick();
    rst = 1'b1;
`else
    hit = 0;
    chk("err_tied", 32'(err | b_err | w_err), 32'(hit));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

endmodule
